// File: rtl/wisc_pkg.sv
// Shared WISC-SP16 encoding definitions: opcodes, instruction formats, field positions.
// Used by both the instruction encoder and the control decoder.
package wisc_pkg;

  localparam int OPC_LSB   = 11;
  localparam int RS_LSB    = 8;
  localparam int RT_LSB    = 5;
  localparam int RD_I1_LSB = 5;
  localparam int RD_R_LSB  = 2;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_SLBI = 5'b10010;
  localparam logic [4:0] OP_LBI  = 5'b11000;
  localparam logic [4:0] OP_ADD  = 5'b11011;

  typedef enum logic [2:0] {FMT_Z, FMT_J, FMT_I1, FMT_I2, FMT_R} fmt_e;

  function automatic fmt_e opc_fmt(input logic [4:0] op);
    fmt_e f;
    casez (op)
      5'b000??:                                     f = FMT_Z;
      5'b00100, 5'b00110:                           f = FMT_J;
      5'b00101, 5'b00111, 5'b011??, 5'b10010,
      5'b11000:                                     f = FMT_I2;
      5'b010??, 5'b10000, 5'b10001, 5'b10011,
      5'b101??:                                     f = FMT_I1;
      default:                                      f = FMT_R;
    endcase
    return f;
  endfunction

  // Opcodes whose immediate is zero-extended rather than sign-extended.
  function automatic logic opc_uimm5(input logic [4:0] op);
    return (op == 5'b01010) || (op == 5'b01011) || (op[4:2] == 3'b101);
  endfunction

  function automatic logic opc_uimm8(input logic [4:0] op);
    return op == OP_SLBI;
  endfunction

endpackage

// File: rtl/wisc_instr_pack.sv
// Combinational packer: decoded fields -> 16-bit WISC-SP16 word, format and
// immediate range fault.
module wisc_instr_pack
  import wisc_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [1:0]  func,
  input  logic [2:0]  rs,
  input  logic [2:0]  rt,
  input  logic [2:0]  rd,
  input  logic [15:0] imm,
  output logic [15:0] word,
  output logic [2:0]  fmt,
  output logic        range_fault
);

  fmt_e       f;
  logic [2:0] i2_src;

  always_comb begin
    f           = opc_fmt(opcode);
    word        = 16'(opcode) << OPC_LSB;
    range_fault = 1'b0;
    // slbi/lbi name their destination in the rs slot
    i2_src      = (opcode == OP_SLBI || opcode == OP_LBI) ? rd : rs;
    unique case (f)
      FMT_Z: ;
      FMT_J: begin
        word        = word | 16'(imm[10:0]);
        range_fault = !((&imm[15:10]) || !(|imm[15:10]));
      end
      FMT_I1: begin
        word        = word | (16'(rs) << RS_LSB) | (16'(rd) << RD_I1_LSB) | 16'(imm[4:0]);
        range_fault = opc_uimm5(opcode) ? (|imm[15:5])
                                        : !((&imm[15:4]) || !(|imm[15:4]));
      end
      FMT_I2: begin
        word        = word | (16'(i2_src) << RS_LSB) | 16'(imm[7:0]);
        range_fault = opc_uimm8(opcode) ? (|imm[15:8])
                                        : !((&imm[15:7]) || !(|imm[15:7]));
      end
      FMT_R: begin
        word = word | (16'(rs) << RS_LSB) | (16'(rt) << RT_LSB)
                    | (16'(rd) << RD_R_LSB) | 16'(func);
      end
      default: ;
    endcase
    fmt = f;
  end

endmodule

// File: rtl/wisc_instr_encoder.sv
// Sequential WISC-SP16 instruction encoder/loader writing packed words to memory.
// Define WISC_ENC_RANGE_CHECK_EN to enable immediate range faults (ERR state).
module wisc_instr_encoder
  import wisc_pkg::*;
#(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic [1:0]  in_func,
  input  logic [2:0]  in_rs,
  input  logic [2:0]  in_rt,
  input  logic [2:0]  in_rd,
  input  logic [15:0] in_imm,
  output logic        mem_wr_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  input  logic        mem_stall,
  output logic        busy,
  output logic        done,
  output logic        full,
  output logic        err,
  output logic [15:0] count
);

`ifdef WISC_ENC_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif
  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_WRITE, S_DONE, S_ERR} state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d, data_q, data_d, count_q, count_d;
  logic        full_q, full_d, err_q, err_d, halt_q, halt_d;
  logic [15:0] pack_word;
  logic [2:0]  pack_fmt;
  logic        pack_fault, fault, last;

  wisc_instr_pack u_pack (
    .opcode     (in_opcode),
    .func       (in_func),
    .rs         (in_rs),
    .rt         (in_rt),
    .rd         (in_rd),
    .imm        (in_imm),
    .word       (pack_word),
    .fmt        (pack_fmt),
    .range_fault(pack_fault)
  );

  assign fault = RANGE_EN & pack_fault;
  assign last  = (count_q + 16'd1) == MAX_W;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    halt_d  = halt_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = {base_addr[15:1], 1'b0};
          count_d = '0;
          full_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          if (fault) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_WRITE;
            data_d  = pack_word;
            // only the all-zero Z-format opcode encodes HALT
            halt_d  = (pack_fmt == 3'(FMT_Z)) && (in_opcode == OP_HALT);
          end
        end
      end
      S_WRITE: begin
        if (!mem_stall) begin
          count_d = count_q + 16'd1;
          addr_d  = addr_q + 16'd2;
          if (halt_q || last) begin
            state_d = S_DONE;
            full_d  = last;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
    end
  end

  assign in_ready  = (state_q == S_RUN);
  assign mem_wr_en = (state_q == S_WRITE);
  assign busy      = (state_q == S_RUN) || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign full      = full_q;
  assign err       = err_q & RANGE_EN;
  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_wisc_instr_encoder.sv
// Randomized self-checking bench for wisc_instr_encoder against an arithmetic
// encoding model; a second instance with MAX_WORDS=2 covers the full condition.
module tb_wisc_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_opcode = '0;
  logic [1:0]  in_func = '0;
  logic [2:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic        mem_stall = 1'b0;

  logic        in_ready, mem_wr_en, busy, done, full, err;
  logic [15:0] mem_addr, mem_data, count;
  logic        m_in_ready, m_mem_wr_en, m_busy, m_done, m_full, m_err;
  logic [15:0] m_mem_addr, m_mem_data, m_count;

  int checks = 0, failures = 0;
  int exp_addr = 0, exp_cnt = 0;
  bit term = 1'b1;
  logic [15:0] obs;

  always #5 clk = ~clk;

  wisc_instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_func(in_func), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_stall(mem_stall), .busy(busy), .done(done), .full(full), .err(err),
    .count(count)
  );

  wisc_instr_encoder #(.MAX_WORDS(2)) dut_max (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(m_in_ready), .in_opcode(in_opcode),
    .in_func(in_func), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .mem_wr_en(m_mem_wr_en), .mem_addr(m_mem_addr), .mem_data(m_mem_data),
    .mem_stall(mem_stall), .busy(m_busy), .done(m_done), .full(m_full), .err(m_err),
    .count(m_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Encoding rules written as field arithmetic on the numeric opcode.
  function automatic void model(input logic [4:0] op, input logic [1:0] fn,
                                input logic [2:0] rs, input logic [2:0] rt,
                                input logic [2:0] rd, input logic [15:0] imm,
                                output logic [15:0] w, output bit flt);
    int o = int'(op);
    int s = int'($signed(imm));
    int u = int'(imm);
    int v;
    flt = 1'b0;
    if (o <= 3) begin
      v = o * 2048;
    end else if (o == 4 || o == 6) begin
      v   = o * 2048 + u % 2048;
      flt = (s < -1024) || (s > 1023);
    end else if (o == 5 || o == 7 || (o >= 12 && o <= 15) || o == 18 || o == 24) begin
      v   = o * 2048 + ((o == 18 || o == 24) ? int'(rd) : int'(rs)) * 256 + u % 256;
      flt = (o == 18) ? (u > 255) : ((s < -128) || (s > 127));
    end else if ((o >= 8 && o <= 11) || o == 16 || o == 17 || (o >= 19 && o <= 23)) begin
      v   = o * 2048 + int'(rs) * 256 + int'(rd) * 32 + u % 32;
      flt = (o == 10 || o == 11 || o >= 20) ? (u > 31) : ((s < -16) || (s > 15));
    end else begin
      v = o * 2048 + int'(rs) * 256 + int'(rt) * 32 + int'(rd) * 4 + int'(fn);
    end
    w = 16'(v);
  endfunction

  task automatic do_start(input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; base_addr = b;
    @(negedge clk);
    start = 1'b0;
    exp_addr = int'(b) & 32'hFFFE; exp_cnt = 0; term = 1'b0;
    chk("start_rdy", in_ready, 1);
    chk("start_cnt", count, 0);
    chk("start_addr", mem_addr, exp_addr);
    chk("start_err", err, 0);
  endtask

  task automatic send(input logic [4:0] op, input logic [1:0] fn, input logic [2:0] rs,
                      input logic [2:0] rt, input logic [2:0] rd, input logic [15:0] imm,
                      input int stalls, output logic [15:0] seen);
    logic [15:0] w;
    bit f;
    int n = 0;
    model(op, fn, rs, rt, rd, imm, w, f);
`ifndef WISC_ENC_RANGE_CHECK_EN
    f = 1'b0;
`endif
    seen = '0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin chk("ready_timeout", 0, 1); return; end
    in_opcode = op; in_func = fn; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    seen = mem_data;
    if (f) begin
      chk("fault_err", err, 1);
      chk("fault_rdy", in_ready, 0);
      chk("fault_wr", mem_wr_en, 0);
      term = 1'b1;
      return;
    end
    chk("wr_en", mem_wr_en, 1);
    chk("addr", mem_addr, exp_addr);
    chk("data", mem_data, w);
    if (stalls > 0) begin
      mem_stall = 1'b1;
      repeat (stalls) begin
        @(negedge clk);
        chk("stall_wr", mem_wr_en, 1);
        chk("stall_addr", mem_addr, exp_addr);
        chk("stall_data", mem_data, w);
        chk("stall_cnt", count, exp_cnt);
      end
      mem_stall = 1'b0;
    end
    @(negedge clk);
    exp_cnt++;
    exp_addr = (exp_addr + 2) % 65536;
    chk("count", count, exp_cnt);
    chk("wr_drop", mem_wr_en, 0);
    if (w == 16'h0000 || exp_cnt == 256) begin
      chk("done", done, 1);
      chk("done_rdy", in_ready, 0);
      chk("full", full, (exp_cnt == 256) ? 1 : 0);
      term = 1'b1;
    end else begin
      chk("rdy_back", in_ready, 1);
      chk("next_addr", mem_addr, exp_addr);
    end
  endtask

  task automatic ensure_stopped();
    logic [15:0] d;
    if (!term) send(5'b00000, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0, 0, d);
  endtask

  initial begin
    logic [15:0] imm;
    int          sel;
    repeat (2) @(negedge clk);
    chk("rst_rdy", in_ready, 0);
    chk("rst_wr", mem_wr_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_flags", {busy, done, full, err}, 0);
    chk("rst_cnt", count, 0);
    rst_n = 1'b1;

    do_start(16'h0100);
    chk("busy_run", busy, 1);
    send(5'b11011, 2'd0, 3'd1, 3'd2, 3'd3, 16'h0, 0, obs);
    chk("tp_add", obs, 16'hD94C);
    send(5'b01000, 2'd0, 3'd1, 3'd0, 3'd2, 16'hFFFF, 0, obs);
    chk("tp_addi", obs, 16'h415F);
    send(5'b11000, 2'd0, 3'd0, 3'd0, 3'd4, 16'h007F, 0, obs);
    chk("tp_lbi", obs, 16'hC47F);
    send(5'b00100, 2'd0, 3'd0, 3'd0, 3'd0, 16'hFFFE, 0, obs);
    chk("tp_j", obs, 16'h27FE);
    send(5'b11001, 2'd3, 3'd7, 3'd5, 3'd6, 16'h0, 3, obs);
    send(5'b01000, 2'd0, 3'd1, 3'd0, 3'd2, 16'd16, 0, obs);
`ifndef WISC_ENC_RANGE_CHECK_EN
    chk("tp_trunc", obs, 16'h4150);
    chk("tp_no_err", err, 0);
`endif
    if (term) do_start(16'h0200);
    send(5'b00000, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0, 0, obs);
    chk("tp_halt", obs, 16'h0000);

    // address wrap past 0xFFFE; odd base is rounded down
    do_start(16'hFFFD);
    repeat (3) send(5'b11100, 2'd1, 3'd2, 3'd3, 3'd4, 16'h0, 0, obs);
    ensure_stopped();

    do_start(16'h0040);
    send(5'b11011, 2'd0, 3'd1, 3'd1, 3'd1, 16'h0, 0, obs);
    send(5'b01000, 2'd0, 3'd3, 3'd0, 3'd4, 16'd5, 1, obs);
    chk("max_full", m_full, 1);
    chk("max_done", m_done, 1);
    chk("max_cnt", m_count, 2);
    chk("max_idle", {m_in_ready, m_mem_wr_en, m_busy, m_err}, 0);
    chk("max_addr", m_mem_addr, exp_addr);
    chk("max_data", m_mem_data, mem_data);
    chk("big_not_full", full, 0);
    ensure_stopped();

    // reset in the middle of a stalled write
    do_start(16'h0300);
    in_opcode = 5'b11011; in_func = 2'd0; in_rs = 3'd1; in_rt = 3'd2; in_rd = 3'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; mem_stall = 1'b1;
    chk("pre_rst_wr", mem_wr_en, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr", mem_wr_en, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_data", mem_data, 0);
    chk("arst_misc", {in_ready, busy, done, full, err}, 0);
    chk("arst_cnt", count, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_stall = 1'b0; term = 1'b1;

    for (int i = 0; i < 60; i++) begin
      if (term) do_start(16'($urandom));
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      imm = 16'($urandom);
      else if (sel == 1) imm = 16'($urandom_range(0, 300));
      else               imm = 16'(int'($urandom_range(0, 40)) - 20);
      send(5'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
           imm, int'($urandom_range(0, 2)), obs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wisc_instr_encoder.md
# wisc_instr_encoder

Sequential instruction encoder and loader for the WISC-SP16 datapath, the inverse of the control decoder. It accepts decoded instruction fields (opcode, func, register numbers, immediate) over a valid/ready handshake and packs them into 16-bit instruction words. It range-checks each immediate and writes the words to consecutive byte addresses of instruction memory through a stallable write port. It is used by the self-test/boot path to assemble programs in hardware before the processor is released from halt.

## Interface
- MAX_WORDS, 256: words written before the block forces DONE (full).
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; leaves IDLE/DONE/ERR, loads mem_addr from base_addr, clears count and flags.
- base_addr  in  16  first byte address; bit 0 ignored (forced 0).
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle.
- in_opcode  in  5  instruction opcode.
- in_func  in  2  R-format function.
- in_rs, in_rt, in_rd  in  3 each  register numbers.
- in_imm  in  16  immediate/displacement, two's complement or unsigned per opcode.
- mem_wr_en  out  1  write request.
- mem_addr  out  16  byte address.
- mem_data  out  16  encoded word.
- mem_stall  in  1  memory not accepting; hold request.
- busy  out  1  state is RUN or WRITE.
- done  out  1  HALT written or full.
- full  out  1  MAX_WORDS reached.
- err  out  1  sticky range fault.
- count  out  16  words written since start.

## Operation
- Formats by opcode:
  - Z: 00000–00011. Word is opcode followed by 11 zero bits.
  - J: 00100, 00110. Word is opcode then imm[10:0].
  - I1: 010xx, 10000, 10001, 10011, 101xx. Word is opcode, rs, rd, imm[4:0].
  - I2: 00101, 00111, 011xx, 10010, 11000. Word is opcode, rs, imm[7:0]; rd is used in the rs slot for 10010 and 11000.
  - R: 11001, 11010, 11011, 111xx. Word is opcode, rs, rt, rd, func.
- Unsigned immediates:
  - 5-bit field: 01010, 01011, 10100–10111; legal range 0..31.
  - 8-bit field: 10010; legal range 0..255.
- Signed immediates: all other I1/I2/J opcodes. Legal ranges are −16..15 (I1), −128..127 (I2), −1024..1023 (J).
- FSM states: IDLE, RUN, WRITE, DONE, ERR.
  - IDLE: waits for start, then goes to RUN.
  - RUN: in_ready=1. On in_valid the word is registered and the state goes to WRITE. On a range fault nothing is written, err is set and the state goes to ERR.
  - WRITE: mem_wr_en=1 with mem_addr/mem_data held stable while mem_stall=1. On the first cycle with mem_stall=0:
    - the write completes, count increments and mem_addr advances by 2;
    - the state goes to DONE if the word was 0x0000 (HALT) or count reaches MAX_WORDS (full=1 in the latter case), otherwise back to RUN.
  - DONE/ERR: hold until start, which re-enters RUN.
- start in RUN/WRITE is ignored.
- mem_addr wraps 0xFFFE→0x0000 silently.

## Timing
- Reset values: in_ready=0, mem_wr_en=0, mem_addr=0, mem_data=0, busy=0, done=0, full=0, err=0, count=0, state IDLE.
- Reset asserted mid-write drops mem_wr_en immediately, with no partial completion.
- Latency: a bundle accepted in cycle N drives mem_wr_en in cycle N+1.
- Peak throughput is one word per 2 cycles; each stall cycle adds one.
- in_ready is registered (state-decoded only) and never depends combinationally on in_valid.
- done/err rise the cycle after the terminating event.
- A start in cycle N gives in_ready=1 in cycle N+1.

## Configuration
- WISC_ENC_RANGE_CHECK_EN defined: immediate range checks active; faults go to ERR as above.
- WISC_ENC_RANGE_CHECK_EN undefined: immediates truncated to field width silently, ERR is unreachable and err ties to 0.

## Structure
- Shared package wisc_pkg:
  - 5-bit opcode constants;
  - format enum (FMT_Z, FMT_J, FMT_I1, FMT_I2, FMT_R);
  - field bit positions;
  - unsigned-immediate opcode list.
  - The control decoder uses the same package.
- Sub-module wisc_instr_pack: purely combinational. It takes the fields and returns word, format and range_fault. The top holds the FSM, address/count and output registers.

## Test plan
- start with base_addr=0x0100, then add rd=3 rs=1 rt=2 (11011, func 00) → one write, mem_addr=0x0100, mem_data=0xD94C, count=1.
- addi rs=1 rd=2 imm=−1 (01000) → 0x415F at 0x0102.
- lbi rd=4 imm=0x7F (11000) → 0xC47F.
- j imm=−2 (00100) → 0x27FE.
- addi imm=16 → no write, err=1 next cycle, in_ready=0.
  - With WISC_ENC_RANGE_CHECK_EN undefined, the same stimulus writes 0x4150 instead.
- mem_stall held for 3 cycles during a write → mem_wr_en high 4 cycles with address/data constant, count increments once.
- halt (00000) → 0x0000 written, then done=1 and in_ready=0.
- MAX_WORDS=2 run → full=1 and done=1 after the second write.
- rst_n pulsed low while in WRITE → all outputs 0 asynchronously.
